// File: rtl/l2_stream_seq_pkg.sv
// Shared types and width helpers for the per-stream L2 sequencer.
package l2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_DRAIN,
    S_RST_ACK,
    S_END
  } l2_seq_state_t;

  function automatic int unsigned l2_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned L2_CACHE_LINE_DEF = 128;
  localparam int unsigned L2_NCL_DEF        = 256;
  localparam int unsigned CACHE_LINE_WIDTH  = l2_width(L2_CACHE_LINE_DEF);
  localparam int unsigned L2_NCL_WIDTH      = l2_width(L2_NCL_DEF);

  typedef logic [L2_NCL_WIDTH:0] l2_occ_t;

endpackage

// File: rtl/l2_occ_cnt.sv
// Up/down occupancy counter with simultaneous inc/dec, clear, and saturation guarded by assertions.
module l2_occ_cnt
  import l2_pkg::*;
#(
  parameter int unsigned width   = $bits(l2_occ_t),
  parameter int unsigned max_val = L2_NCL_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [width-1:0] cnt
);

  logic [width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      if (cnt_q != width'(max_val)) cnt_d = cnt_q + width'(1);
    end else if (dec && !inc) begin
      if (cnt_q != '0) cnt_d = cnt_q - width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(!clr && inc && !dec && cnt_q == width'(max_val)));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(!clr && dec && !inc && cnt_q == '0));

endmodule

// File: rtl/l2_stream_seq.sv
// Per-stream L2 sequencer: issues host line requests up to an exclusive end EA, tracks
// in-order responses, hands URAM read pointers to L1, and supports drain-then-reload reset.
module l2_stream_seq
  import l2_pkg::*;
#(
  parameter int unsigned addr_width = 64,
  parameter int unsigned cache_line = 128,
  parameter int unsigned l2_ncl     = 256,
  parameter int unsigned max_outst  = 32,
  localparam int unsigned l2_ncl_width = l2_width(l2_ncl)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_rst_v,
  output logic                    i_rst_r,
  input  logic [addr_width-1:0]   i_rst_ea,
  input  logic [addr_width-1:0]   i_rst_end_ea,
  output logic                    o_rst_v,
  input  logic                    o_rst_r,
  input  logic                    i_rd_v,
  output logic                    i_rd_r,
  output logic                    o_addr_v,
  input  logic                    o_addr_r,
  output logic [l2_ncl_width-1:0] o_addr_ptr,
  output logic                    o_req_v,
  input  logic                    o_req_r,
  output logic [addr_width-1:0]   o_req_ea,
  input  logic                    i_rsp_v,
  output logic                    i_rsp_r,
  output logic                    o_end_v,
  input  logic                    o_end_r
);

  localparam int unsigned cache_line_width = l2_width(cache_line);
  localparam int unsigned occ_w = l2_ncl_width + 1;
  localparam logic [addr_width-1:0] line_step = addr_width'(64'd1 << cache_line_width);
  localparam logic [addr_width-1:0] line_mask = ~(line_step - addr_width'(1));
  localparam logic [occ_w:0]        ncl_lim   = (occ_w + 1)'(l2_ncl);
  localparam logic [occ_w-1:0]      outst_lim = occ_w'(max_outst);

  l2_seq_state_t state_q, state_d, rst_tgt;
  logic [addr_width-1:0]   req_ea_q, req_ea_d, end_ea_q, end_ea_d;
  logic [addr_width-1:0]   rst_ea_q, rst_ea_d, rst_end_q, rst_end_d;
  logic [l2_ncl_width-1:0] rd_ptr_q, rd_ptr_d, addr_ptr_q, addr_ptr_d;
  logic                    addr_v_q, addr_v_d;
  logic [occ_w-1:0]        inflight, filled, inflight_nxt;
  logic [occ_w:0]          occ_sum;
  logic req_fire, rsp_fire, rd_fire, rst_fire, filled_inc, filled_clr;

  assign i_rst_r  = state_q inside {S_IDLE, S_ACTIVE, S_END};
  assign o_rst_v  = (state_q == S_RST_ACK);
  assign o_end_v  = (state_q == S_END);
  assign i_rsp_r  = (state_q != S_IDLE);
  assign occ_sum  = {1'b0, inflight} + {1'b0, filled};
  assign o_req_v  = (state_q == S_ACTIVE) && (req_ea_q != end_ea_q) &&
                    (occ_sum < ncl_lim) && (inflight < outst_lim);
  assign i_rd_r   = (state_q == S_ACTIVE) && (filled != '0) && (!addr_v_q || o_addr_r);
  assign o_req_ea = req_ea_q;
  assign o_addr_v   = addr_v_q;
  assign o_addr_ptr = addr_ptr_q;

  assign req_fire   = o_req_v && o_req_r;
  assign rsp_fire   = i_rsp_v && i_rsp_r;
  assign rd_fire    = i_rd_v && i_rd_r;
  assign rst_fire   = i_rst_v && i_rst_r;
  assign filled_inc = rsp_fire && (state_q != S_DRAIN);
  assign filled_clr = (state_q == S_RST_ACK);

  // Drain decisions look at next-cycle inflight so a request/response on the same edge is counted.
  assign inflight_nxt = inflight + occ_w'(req_fire) - occ_w'(rsp_fire);

  always_comb begin
    state_d    = state_q;
    req_ea_d   = req_ea_q;
    end_ea_d   = end_ea_q;
    rst_ea_d   = rst_ea_q;
    rst_end_d  = rst_end_q;
    rd_ptr_d   = rd_ptr_q;
    addr_v_d   = addr_v_q;
    addr_ptr_d = addr_ptr_q;
    rst_tgt    = (inflight_nxt != '0) ? S_DRAIN : S_RST_ACK;

    if (rst_fire) begin
      rst_ea_d  = i_rst_ea & line_mask;
      rst_end_d = i_rst_end_ea & line_mask;
    end
    if (req_fire) req_ea_d = req_ea_q + line_step;
    if (o_addr_r) addr_v_d = 1'b0;
    if (rd_fire) begin
      addr_v_d   = 1'b1;
      addr_ptr_d = rd_ptr_q;
      rd_ptr_d   = rd_ptr_q + l2_ncl_width'(1);
    end

    unique case (state_q)
      S_IDLE: if (rst_fire) state_d = rst_tgt;
      S_ACTIVE: begin
        if (rst_fire) state_d = rst_tgt;
        else if ((req_ea_q == end_ea_q) && (inflight == '0) && (filled == '0) && !rd_fire)
          state_d = S_END;
      end
      S_DRAIN: if (inflight_nxt == '0) state_d = S_RST_ACK;
      S_RST_ACK: begin
        req_ea_d = rst_ea_q;
        end_ea_d = rst_end_q;
        rd_ptr_d = '0;
        if (o_rst_r) state_d = (rst_ea_q == rst_end_q) ? S_END : S_ACTIVE;
      end
      S_END: begin
        if (rst_fire)     state_d = rst_tgt;
        else if (o_end_r) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      req_ea_q   <= '0;
      end_ea_q   <= '0;
      rst_ea_q   <= '0;
      rst_end_q  <= '0;
      rd_ptr_q   <= '0;
      addr_v_q   <= 1'b0;
      addr_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      req_ea_q   <= req_ea_d;
      end_ea_q   <= end_ea_d;
      rst_ea_q   <= rst_ea_d;
      rst_end_q  <= rst_end_d;
      rd_ptr_q   <= rd_ptr_d;
      addr_v_q   <= addr_v_d;
      addr_ptr_q <= addr_ptr_d;
    end
  end

  l2_occ_cnt #(.width(occ_w), .max_val(l2_ncl)) u_inflight (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (req_fire),
    .dec   (rsp_fire),
    .cnt   (inflight)
  );

  l2_occ_cnt #(.width(occ_w), .max_val(l2_ncl)) u_filled (
    .clk   (clk),
    .reset (reset),
    .clr   (filled_clr),
    .inc   (filled_inc),
    .dec   (rd_fire),
    .cnt   (filled)
  );

  a_no_rsp_in_idle: assert property (@(posedge clk) disable iff (reset)
    !(i_rsp_v && state_q == S_IDLE));

endmodule

// File: doc/l2_stream_seq.md
# l2_stream_seq

Per-stream L2 sequencer, the next generation of the per-stream pointer unit instantiated `nstrms` times under the L2 control top. It adds the following over the current unit:
- an exclusive end address per stream, with a stream END handshake;
- a parametrised outstanding-request limit;
- full/empty occupancy accounting over a parametrised URAM window;
- a drain-then-reload functional reset that is legal mid-stream.

It issues host cache-line requests, tracks in-order responses, and emits URAM read pointers for L1 reads.

## Interface
Parameters:
- `addr_width`, 64, host EA width in bits.
- `cache_line`, 128, host cache line size in bytes; `cache_line_width` = $clog2(cache_line).
- `l2_ncl`, 256, cache lines per stream in L2 (power of 2); `l2_ncl_width` = $clog2(l2_ncl).
- `max_outst`, 32, max host requests in flight (1..l2_ncl).

Ports:
- `clk`  in  1  clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `i_rst_v` / `i_rst_r`  in/out  1  functional stream reset handshake.
- `i_rst_ea`  in  addr_width  stream start EA.
- `i_rst_end_ea`  in  addr_width  stream end EA (exclusive).
- `o_rst_v` / `o_rst_r`  out/in  1  reset-complete acknowledge.
- `i_rd_v` / `i_rd_r`  in/out  1  L1 consumes one line.
- `o_addr_v` / `o_addr_r`  out/in  1  URAM read request.
- `o_addr_ptr`  out  l2_ncl_width  URAM slot to read.
- `o_req_v` / `o_req_r`  out/in  1  host request.
- `o_req_ea`  out  addr_width  line-aligned request EA.
- `i_rsp_v` / `i_rsp_r`  in/out  1  host response for this stream, in order.
- `o_end_v` / `o_end_r`  out/in  1  stream END.

## Operation
- State: IDLE, ACTIVE, DRAIN, RST_ACK, END.
- Registers:
  - `req_ea`, `end_ea`: low `cache_line_width` bits forced to 0 on load.
  - `rd_ptr`: l2_ncl_width bits, wraps from l2_ncl-1 to 0.
  - `inflight`, `filled`: l2_ncl_width+1 bits each.
- `i_rst_r` = state ∈ {IDLE, ACTIVE, END}. On accept:
  - capture start and end EA;
  - go to DRAIN if `inflight` != 0, else RST_ACK.
- DRAIN: no new requests. Responses are still accepted and counted. Exit to RST_ACK when `inflight` == 0.
- RST_ACK:
  - load `req_ea` and `end_ea`; clear `filled` and `rd_ptr`; assert `o_rst_v`;
  - on `o_rst_r`, go to ACTIVE, or to END if start == end.
- `o_req_v` = ACTIVE & (`req_ea` != `end_ea`) & (`inflight` + `filled` < l2_ncl) & (`inflight` < max_outst). `o_req_ea` = `req_ea`.
  - On handshake: `req_ea` += cache_line; `inflight`++.
- `i_rsp_r` = 1 in every state except IDLE. On response: `inflight`--, and `filled`++ unless state is DRAIN.
- `i_rd_r` = ACTIVE & `filled` != 0 & (!`o_addr_v` | `o_addr_r`).
  - On accept: `o_addr_v` <= 1, `o_addr_ptr` <= `rd_ptr`, `rd_ptr`++, `filled`--.
- ACTIVE → END when all of the following hold: `req_ea` == `end_ea`, `inflight` == 0, `filled` == 0, no read accepted this cycle.
- END: `o_end_v` = 1; on `o_end_r`, go to IDLE. A functional reset accepted in END takes priority over `o_end_r`.
- Simultaneous events:
  - request + response in the same cycle: `inflight` unchanged;
  - response + read in the same cycle: `filled` unchanged.
- A pending `o_addr_v` is never dropped. It holds through functional reset until `o_addr_r`.
- A response arriving in IDLE is a protocol error; this is a simulation assertion only.

## Timing
- After `reset`: state IDLE; all counters 0; outputs `o_rst_v`, `o_addr_v`, `o_req_v`, `o_end_v` = 0; `i_rd_r` = 0; `i_rsp_r` = 0; `i_rst_r` = 1.
- Latencies:
  - `i_rst` accept to `o_rst_v`: 1 cycle when nothing is in flight; otherwise the drain time + 1.
  - `o_rst` handshake to first `o_req_v`: 1 cycle.
  - `i_rsp` to `i_rd_r` rising: 1 cycle.
  - `i_rd` accept to `o_addr_v`: 1 cycle, registered.
- `o_req_v` and `i_rd_r` are combinational from registers only. They have no dependency on their own ready inputs.
- Full-rate operation: one request, one response and one read per cycle, all simultaneously, is sustainable.

## Structure
- Package `l2_pkg` holds:
  - the state enum `l2_seq_state_t`;
  - localparam helpers for `cache_line_width` and `l2_ncl_width`;
  - the occupancy type `l2_occ_t` (l2_ncl_width+1 bits).
- Sub-module `l2_occ_cnt`: saturating-assert up/down counter with simultaneous inc/dec. It is instantiated twice, for `inflight` and `filled`.
- The new top integrates via `base_areg` input registers, as with the current pointer unit.

## Test plan
- Start EA 0x1000, end 0x1400, l2_ncl=256, `o_req_r`=1 → exactly 8 requests at EA 0x1000..0x1380. After 8 responses and 8 reads: `o_addr_ptr` 0..7, then `o_end_v`.
- `max_outst`=4, responses withheld → `o_req_v` drops after 4 requests. One response releases exactly one more request.
- l2_ncl=8, reads withheld, long stream → 8 requests then `o_req_v`=0 (full). Reads then proceed; `rd_ptr` wraps 7→0 and requests resume.
- Functional reset with `inflight`=3 → state DRAIN, `o_rst_v` low. After the third response `o_rst_v` rises 1 cycle later, and the next request is at the new start EA.
- Start == end (0x2000) → after `o_rst` handshake, `o_end_v` rises next cycle and no requests are issued.
- Same-cycle request, response and read for 100 cycles at steady state → `inflight` and `filled` unchanged, throughput 1/cycle.
